multicycle_ctrl: RTL
====================

# multicycle_ctrl

Finite-state controller that sequences the team's MIPS-subset datapath as a multi-cycle machine. One instruction register, one ALU and one unified memory port are reused across cycles. The block issues all datapath enables and mux selects each cycle, stalls on a memory ready handshake, and traps on unknown opcodes. It sits beside the datapath and is the only source of PC, IR, register-file and memory write strobes.

## Interface
- No parameters.
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous reset, active-high
- opcode_i  in  6  IR[31:26], stable from DECODE onward
- funct_i  in  6  IR[5:0]
- alu_zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC load enable
- pc_src_o  out  2  0 ALU result (PC+4), 1 ALUOut (branch target), 2 jump address, 3 RS data
- ir_write_o  out  1  IR load enable
- iord_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_o / mem_write_o  out  1 each  memory strobes
- reg_write_o  out  1  register-file write
- reg_dst_o  out  2  0 rt, 1 rd, 2 $31
- mem_to_reg_o  out  2  0 ALUOut, 1 MDR, 2 PC
- alu_src_a_o  out  1  0 PC, 1 RS
- alu_src_b_o  out  2  0 RT, 1 const 4, 2 sign-ext, 3 sign-ext<<2
- alu_op_o  out  4  0 ADD, 1 SUB, 2 RTYPE (funct decides), 3 SLT
- trap_o  out  1  sticky illegal-opcode flag
- state_o  out  4  current state encoding (debug)

## Operation
- Supported instructions: R-type (0x00), jr (R, funct 0x08), j 0x02, jal 0x03, beq 0x04, bne 0x05, addi 0x08, slti 0x0A, lw 0x23, sw 0x2B.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC 7, R_WB 8, BRANCH 9, JUMP 10, IMM_EXEC 11, IMM_WB 12, TRAP 13.
- Transitions:
  - IDLE → FETCH.
  - FETCH: iord=0, mem_read=1, ALU PC+4. On mem_ready_i, pulse ir_write and pc_write (pc_src=0), then → DECODE. Otherwise hold, with both enables low.
  - DECODE: ALU computes PC + (imm<<2) into ALUOut (src_a=0, src_b=3, ADD). Dispatch on opcode:
    - lw/sw → MEM_ADDR
    - R (non-jr) → EXEC
    - jr, j, jal → JUMP
    - beq/bne → BRANCH
    - addi/slti → IMM_EXEC
    - any other opcode → TRAP
  - MEM_ADDR: RS + sign-ext, ADD. lw → MEM_RD; sw → MEM_WR.
  - MEM_RD: iord=1, mem_read=1. Hold until mem_ready_i, then → MEM_WB.
  - MEM_WB: reg_write, reg_dst=0, mem_to_reg=1. Then → FETCH.
  - MEM_WR: iord=1, mem_write=1. Hold until mem_ready_i, then → FETCH.
  - EXEC: src_a=1, src_b=0, RTYPE. Then → R_WB.
  - R_WB: reg_write, reg_dst=1, mem_to_reg=0. Then → FETCH.
  - BRANCH: src_a=1, src_b=0, SUB. pc_src=1. pc_write = (beq & zero) | (bne & ~zero). Then → FETCH.
  - JUMP: pc_write=1. pc_src=3 for jr, otherwise 2. For jal, also reg_write, reg_dst=2, mem_to_reg=2. Then → FETCH.
  - IMM_EXEC: src_a=1, src_b=2. ADD for addi, SLT for slti. Then → IMM_WB.
  - IMM_WB: reg_write, reg_dst=0, mem_to_reg=0. Then → FETCH.
  - TRAP: all strobes 0, trap_o=1. Only reset exits TRAP.
- Outputs are Moore-style, decoded from state plus the registered opcode/funct. The exceptions are mem_ready_i gating in FETCH and alu_zero_i gating in BRANCH, which are combinational.
- Don't-care selects drive 0.

## Timing
- Reset: state=IDLE. Every output is 0, including trap_o, and is forced 0 asynchronously as rst_i rises, even mid-instruction or mid-stall.
- First FETCH occurs the cycle after reset deasserts plus one (the IDLE cycle).
- Cycles per instruction with mem_ready_i tied high: lw 5, sw 4, R/addi/slti 4, beq/bne/j/jal/jr 3.
- Each cycle mem_ready_i is low in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Write strobes are asserted for exactly one cycle per instruction. mem_read_o and mem_write_o stay high for the full stall.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.

## Configuration
- MULTICYCLE_CTRL_PERF_EN defined: two extra 32-bit outputs, cycle_cnt_o and instr_cnt_o, are present.
  - cycle_cnt_o increments every cycle out of reset, except in TRAP.
  - instr_cnt_o increments on each → FETCH transition from a non-IDLE state.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Control behaviour is identical either way.

## Structure
- Package multicycle_ctrl_pkg holds:
  - the state enum with the encodings above
  - opcode constants and the funct JR constant
  - the ALU-op, pc_src, reg_dst, mem_to_reg and alu_src_b encodings
- One sub-module: multicycle_ctrl_decode. It is a combinational opcode/funct classifier that outputs an instruction-class one-hot plus an illegal flag, and is used in DECODE dispatch.

## Test plan
- Reset asserted in MEM_RD with mem_read_o=1 → all outputs 0 within the same cycle. After release: IDLE, then FETCH.
- lw (0x23) with mem_ready_i always 1 → states 1,2,3,4,5,1. reg_write_o=1 only in state 5, with mem_to_reg_o=1.
- FETCH with mem_ready_i low for 3 cycles → state_o holds 1 for 4 cycles. ir_write_o and pc_write_o pulse once, on the 4th cycle.
- beq with alu_zero_i=1 → pc_write_o=1 and pc_src_o=1 in BRANCH. bne with alu_zero_i=1 → pc_write_o=0.
- jal (0x03) → JUMP asserts pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2. jr (funct 0x08) → pc_src_o=3, reg_write_o=0.
- Opcode 0x3F → TRAP with trap_o=1, which stays through 10 further cycles and clears only on rst_i. With MULTICYCLE_CTRL_PERF_EN, cycle_cnt_o is frozen while in TRAP.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states, opcodes,
// datapath select codes, the instruction-class index map and the control bundle.
package multicycle_ctrl_pkg;

  // State encoding (also exported on state_o for debug)
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_FETCH    = 4'd1;
  localparam state_t S_DECODE   = 4'd2;
  localparam state_t S_MEM_ADDR = 4'd3;
  localparam state_t S_MEM_RD   = 4'd4;
  localparam state_t S_MEM_WB   = 4'd5;
  localparam state_t S_MEM_WR   = 4'd6;
  localparam state_t S_EXEC     = 4'd7;
  localparam state_t S_R_WB     = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JUMP     = 4'd10;
  localparam state_t S_IMM_EXEC = 4'd11;
  localparam state_t S_IMM_WB   = 4'd12;
  localparam state_t S_TRAP     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic SRC_A_PC = 1'b0;
  localparam logic SRC_A_RS = 1'b1;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_SEXT    = 2'd2;
  localparam logic [1:0] SRC_B_SEXT_SH = 2'd3;

  // Bit positions of the instruction-class one-hot
  localparam int CL_R        = 0;
  localparam int CL_JR       = 1;
  localparam int CL_J        = 2;
  localparam int CL_JAL      = 3;
  localparam int CL_BEQ      = 4;
  localparam int CL_BNE      = 5;
  localparam int CL_ADDI     = 6;
  localparam int CL_SLTI     = 7;
  localparam int CL_LW       = 8;
  localparam int CL_SW       = 9;
  localparam int NUM_CLASSES = 10;

  typedef logic [NUM_CLASSES-1:0] iclass_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       trap;
  } ctrl_t;

  // Opcode owned by each class that is identified by opcode alone
  function automatic logic [5:0] class_opcode(input int idx);
    case (idx)
      CL_J:    class_opcode = OP_J;
      CL_JAL:  class_opcode = OP_JAL;
      CL_BEQ:  class_opcode = OP_BEQ;
      CL_BNE:  class_opcode = OP_BNE;
      CL_ADDI: class_opcode = OP_ADDI;
      CL_SLTI: class_opcode = OP_SLTI;
      CL_LW:   class_opcode = OP_LW;
      CL_SW:   class_opcode = OP_SW;
      default: class_opcode = OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct classifier: one-hot instruction class plus an
// illegal flag when no supported instruction matches.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic       illegal
);

  // Opcode 0 splits on funct: jr is a jump, everything else is an ALU op
  assign iclass[CL_R]  = (opcode == OP_RTYPE) && (funct != FUNCT_JR);
  assign iclass[CL_JR] = (opcode == OP_RTYPE) && (funct == FUNCT_JR);

  genvar gi;
  generate
    for (gi = CL_J; gi < NUM_CLASSES; gi++) begin : g_op_match
      assign iclass[gi] = (opcode == class_opcode(gi));
    end
  endgenerate

  assign illegal = ~|iclass;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset controller: FSM sequencing fetch/decode/execute with
// memory-ready stalls and a sticky illegal-opcode trap.
// Optional MULTICYCLE_CTRL_PERF_EN adds cycle_cnt_o / instr_cnt_o counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        alu_zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic [1:0]  pc_src_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic [1:0]  reg_dst_o,
  output logic [1:0]  mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [3:0]  alu_op_o,
  output logic        trap_o,
  output logic [3:0]  state_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
`endif
);

  state_t  state_reg, state_next;
  iclass_t dec_class, cls_reg;
  logic    dec_illegal;
  ctrl_t   ctrl;

  multicycle_ctrl_decode u_decode (
    .opcode  (opcode_i),
    .funct   (funct_i),
    .iclass  (dec_class),
    .illegal (dec_illegal)
  );

  // The class is captured leaving DECODE so later states do not depend on IR timing
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      cls_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        cls_reg <= dec_class;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)
          state_next = S_TRAP;
        else if (dec_class[CL_LW] || dec_class[CL_SW])
          state_next = S_MEM_ADDR;
        else if (dec_class[CL_R])
          state_next = S_EXEC;
        else if (dec_class[CL_JR] || dec_class[CL_J] || dec_class[CL_JAL])
          state_next = S_JUMP;
        else if (dec_class[CL_BEQ] || dec_class[CL_BNE])
          state_next = S_BRANCH;
        else
          state_next = S_IMM_EXEC;
      end
      S_MEM_ADDR: state_next = cls_reg[CL_LW] ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready_i) state_next = S_FETCH;
      S_EXEC:     state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_IMM_EXEC: state_next = S_IMM_WB;
      S_IMM_WB:   state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_IDLE;
    endcase
  end

  // Moore decode; only FETCH (mem_ready) and BRANCH (alu_zero) look at live inputs
  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_SEXT_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS;
        ctrl.alu_src_b = SRC_B_SEXT;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = SRC_A_RS;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRC_A_RS;
        ctrl.alu_src_b = SRC_B_RT;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_ALUOUT;
        ctrl.pc_write  = (cls_reg[CL_BEQ] & alu_zero_i) | (cls_reg[CL_BNE] & ~alu_zero_i);
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = cls_reg[CL_JR] ? PC_SRC_RS : PC_SRC_JUMP;
        if (cls_reg[CL_JAL]) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = REG_DST_RA;
          ctrl.mem_to_reg = M2R_PC;
        end
      end
      S_IMM_EXEC: begin
        ctrl.alu_src_a = SRC_A_RS;
        ctrl.alu_src_b = SRC_B_SEXT;
        ctrl.alu_op    = cls_reg[CL_SLTI] ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
      end
      S_TRAP:  ctrl.trap = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Classes that only steer DECODE dispatch, never a later state
  logic unused_cls;
  assign unused_cls = ^{cls_reg[CL_R], cls_reg[CL_J], cls_reg[CL_ADDI], cls_reg[CL_SW]};

  assign pc_write_o   = ctrl.pc_write;
  assign pc_src_o     = ctrl.pc_src;
  assign ir_write_o   = ctrl.ir_write;
  assign iord_o       = ctrl.iord;
  assign mem_read_o   = ctrl.mem_read;
  assign mem_write_o  = ctrl.mem_write;
  assign reg_write_o  = ctrl.reg_write;
  assign reg_dst_o    = ctrl.reg_dst;
  assign mem_to_reg_o = ctrl.mem_to_reg;
  assign alu_src_a_o  = ctrl.alu_src_a;
  assign alu_src_b_o  = ctrl.alu_src_b;
  assign alu_op_o     = ctrl.alu_op;
  assign trap_o       = ctrl.trap;
  assign state_o      = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_reg, instr_cnt_reg;

  // FETCH self-loops are stalls, not new instructions
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_cnt_reg <= '0;
      instr_cnt_reg <= '0;
    end else begin
      if (state_reg != S_TRAP) begin
        cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
      if (state_next == S_FETCH && state_reg != S_IDLE && state_reg != S_FETCH) begin
        instr_cnt_reg <= instr_cnt_reg + 32'd1;
      end
    end
  end

  assign cycle_cnt_o = cycle_cnt_reg;
  assign instr_cnt_o = instr_cnt_reg;
`endif

endmodule
